// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 VGA raster timing generator (800x525 total).
// DrawX/DrawY come straight from the counter registers. hs/vs/blank are
// registered from the next counter values, so they line up with DrawX/DrawY
// in the same cycle.
// Optional feature: define VGA_FRAME_COUNT_EN to add the 16-bit frame_cnt port.
module vga_timing_gen (
  input  logic       vga_clk,
  input  logic       reset_n,
  input  logic       pixel_en,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       frame_start,
  output logic       line_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  // Horizontal timing, in pixels
  localparam logic [9:0] H_VISIBLE    = 10'd640;
  localparam logic [9:0] H_SYNC_FIRST = 10'd656;
  localparam logic [9:0] H_SYNC_LAST  = 10'd751;
  localparam logic [9:0] H_LAST       = 10'd799;

  // Vertical timing, in lines
  localparam logic [9:0] V_VISIBLE    = 10'd480;
  localparam logic [9:0] V_SYNC_FIRST = 10'd490;
  localparam logic [9:0] V_SYNC_LAST  = 10'd491;
  localparam logic [9:0] V_LAST       = 10'd524;

  logic [9:0] hc_reg;
  logic [9:0] vc_reg;
  logic [9:0] hc_next;
  logic [9:0] vc_next;
  logic       h_wrap;
  logic       v_wrap;
  logic       hs_next;
  logic       vs_next;
  logic       blank_next;

  logic       hs_reg;
  logic       vs_reg;
  logic       blank_reg;
  logic       frame_start_reg;
  logic       line_start_reg;

  // Next counter values. Everything holds when pixel_en is low.
  always_comb begin
    hc_next = hc_reg;
    vc_next = vc_reg;
    h_wrap  = 1'b0;
    v_wrap  = 1'b0;
    if (pixel_en) begin
      if (hc_reg == H_LAST) begin
        hc_next = 10'd0;
        h_wrap  = 1'b1;
        if (vc_reg == V_LAST) begin
          vc_next = 10'd0;
          v_wrap  = 1'b1;
        end else begin
          vc_next = vc_reg + 10'd1;
        end
      end else begin
        hc_next = hc_reg + 10'd1;
      end
    end
  end

  // Decode sync and visible region from the next counter values. They are
  // registered so that they match DrawX/DrawY after the clock edge.
  always_comb begin
    hs_next    = ~((hc_next >= H_SYNC_FIRST) && (hc_next <= H_SYNC_LAST));
    vs_next    = ~((vc_next >= V_SYNC_FIRST) && (vc_next <= V_SYNC_LAST));
    blank_next = (hc_next < H_VISIBLE) && (vc_next < V_VISIBLE);
  end

  // Raster counters. Reset parks the scan at (0,0) immediately.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc_reg <= 10'd0;
      vc_reg <= 10'd0;
    end else begin
      hc_reg <= hc_next;
      vc_reg <= vc_next;
    end
  end

  // Registered sync/blank. Their reset values match the decode at (0,0).
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_reg    <= 1'b1;
      vs_reg    <= 1'b1;
      blank_reg <= 1'b1;
    end else begin
      hs_reg    <= hs_next;
      vs_reg    <= vs_next;
      blank_reg <= blank_next;
    end
  end

  // Pulses fire only on a real wrap into column 0. Reset itself does not count.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      line_start_reg  <= h_wrap;
      frame_start_reg <= h_wrap & v_wrap;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_cnt_reg;

  // Frame counter steps in the same cycle that frame_start goes high, and wraps mod 2^16.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_reg <= 16'd0;
    end else if (h_wrap && v_wrap) begin
      frame_cnt_reg <= frame_cnt_reg + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_reg;
`endif

  assign DrawX       = hc_reg;
  assign DrawY       = vc_reg;
  assign hs          = hs_reg;
  assign vs          = vs_reg;
  assign blank       = blank_reg;
  assign line_start  = line_start_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen. A raster model pushes
// the expected output set when it drives pixel_en. That entry is popped and
// compared on the following falling edge.
// Define VGA_FRAME_COUNT_EN to also exercise frame_cnt.
module tb_vga_timing_gen;

  logic       vga_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       pixel_en = 1'b0;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       blank;
  logic       hs;
  logic       vs;
  logic       frame_start;
  logic       line_start;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] frame_cnt;
`endif

  int checks = 0;
  int failures = 0;

  // Reference raster model
  int          mhc;
  int          mvc;
  bit          mfs;
  bit          mls;
  int unsigned mfc;

  logic [31:0] sb[$];

  vga_timing_gen dut (
    .vga_clk    (vga_clk),
    .reset_n    (reset_n),
    .pixel_en   (pixel_en),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .blank      (blank),
    .hs         (hs),
    .vs         (vs),
    .frame_start(frame_start),
    .line_start (line_start)
`ifdef VGA_FRAME_COUNT_EN
    ,
    .frame_cnt  (frame_cnt)
`endif
  );

  always #5 vga_clk = ~vga_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      if (failures <= 20)
        $display("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mhc = 0;
    mvc = 0;
    mfs = 1'b0;
    mls = 1'b0;
    mfc = 0;
  endtask

  task automatic model_step(input bit en);
    mfs = 1'b0;
    mls = 1'b0;
    if (en) begin
      if (mhc == 799) begin
        mhc = 0;
        mls = 1'b1;
        if (mvc == 524) begin
          mvc = 0;
          mfs = 1'b1;
          mfc = (mfc + 1) & 32'h0000_ffff;
        end else begin
          mvc = mvc + 1;
        end
      end else begin
        mhc = mhc + 1;
      end
    end
  endtask

  function automatic logic [31:0] exp_pack();
    logic hs_e;
    logic vs_e;
    logic blank_e;
    hs_e    = !(mhc >= 656 && mhc <= 751);
    vs_e    = !(mvc >= 490 && mvc <= 491);
    blank_e = (mhc < 640) && (mvc < 480);
    return {7'd0, mhc[9:0], mvc[9:0], hs_e, vs_e, blank_e, mfs, mls};
  endfunction

  function automatic logic [31:0] dut_pack();
    return {7'd0, DrawX, DrawY, hs, vs, blank, frame_start, line_start};
  endfunction

  // One pixel clock: drive, predict, then compare on the falling edge.
  task automatic cycle(input bit en);
    pixel_en = en;
    model_step(en);
    sb.push_back(exp_pack());
    @(negedge vga_clk);
    check_eq("outputs", dut_pack(), sb.pop_front());
`ifdef VGA_FRAME_COUNT_EN
    check_eq("frame_cnt", {16'd0, frame_cnt}, mfc);
`endif
  endtask

  // One clock with reset held. pixel_en is high so that an ignored reset would show.
  task automatic reset_cycle();
    reset_n  = 1'b0;
    pixel_en = 1'b1;
    model_reset();
    sb.push_back(exp_pack());
    @(negedge vga_clk);
    check_eq("reset_hold", dut_pack(), sb.pop_front());
`ifdef VGA_FRAME_COUNT_EN
    check_eq("reset_frame_cnt", {16'd0, frame_cnt}, 32'd0);
`endif
  endtask

  initial begin
    int n;
    model_reset();
    reset_n  = 1'b0;
    pixel_en = 1'b0;
    @(negedge vga_clk);
    repeat (3) reset_cycle();

    // Release: the first enabled edge moves to (1,0) with no frame_start.
    reset_n = 1'b1;
    cycle(1'b1);
    check_eq("first_x", {22'd0, DrawX}, 32'd1);
    repeat (1700) cycle(1'b1);

    // Half-rate pixel_en
    for (int c = 0; c < 1700; c++) cycle(c[0] == 1'b0);

    // Random qualifier
    repeat (200) cycle(1'($urandom_range(0, 1)));

    // Jump to line 478, then run through the end of the frame and wrap.
    pixel_en = 1'b0;
    force dut.vc_reg = 10'd478;
`ifdef VGA_FRAME_COUNT_EN
    force dut.frame_cnt_reg = 16'hffff;
`endif
    @(negedge vga_clk);
    release dut.vc_reg;
`ifdef VGA_FRAME_COUNT_EN
    release dut.frame_cnt_reg;
    mfc = 32'h0000_ffff;
`endif
    mvc = 478;
    n = 0;
    do begin
      cycle(1'b1);
      n++;
    end while (!(mvc == 1 && mhc == 0) && n < 40000);
    if (n >= 40000) check_eq("frame_wrap_timeout", 32'd0, 32'd1);

    // Jump into vertical sync and stop at (700,491), where hs and vs are both low.
    pixel_en = 1'b0;
    force dut.vc_reg = 10'd490;
    @(negedge vga_clk);
    release dut.vc_reg;
    mvc = 490;
    n = 0;
    do begin
      cycle(1'b1);
      n++;
    end while (!(mvc == 491 && mhc == 700) && n < 2000);
    if (n >= 2000) check_eq("sync_seek_timeout", 32'd0, 32'd1);
    check_eq("hs_in_sync", {31'd0, hs}, 32'd0);
    check_eq("vs_in_sync", {31'd0, vs}, 32'd0);

    // Asynchronous reset between clock edges.
    pixel_en = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_eq("async_reset", dut_pack(), exp_pack());
    @(negedge vga_clk);
    repeat (2) reset_cycle();
    reset_n = 1'b1;
    repeat (900) cycle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 vga_clk  input  1  pixel-domain clock, all state on rising edge.
REQ-002 reset_n  input  1  reset, asynchronous, active-low.
REQ-003 pixel_en  input  1  pixel-advance qualifier, 1 = counters step this cycle; tie 1 for a 25 MHz vga_clk.
REQ-004 DrawX  output  10  current horizontal pixel index, 0..799.
REQ-005 DrawY  output  10  current vertical line index, 0..524.
REQ-006 blank  output  1  1 = (DrawX,DrawY) in visible 640x480 region; sprite/palette consumers drive colour only when 1.
REQ-007 hs  output  1  horizontal sync, active-low.
REQ-008 vs  output  1  vertical sync, active-low.
REQ-009 frame_start  output  1  one-cycle pulse on entry to (0,0).
REQ-010 line_start  output  1  one-cycle pulse on entry to DrawX=0 on any line.
REQ-011 frame_cnt  output  16  frame counter, present only with VGA_FRAME_COUNT_EN.

Function
REQ-012 Horizontal counter hc SHALL count 0..799 and wrap to 0; visible 0-639, front porch 640-655, sync 656-751, back porch 752-799.
REQ-013 Vertical counter vc SHALL increment only when hc wraps 799->0, count 0..524 and wrap to 0; visible 0-479, front porch 480-489, sync 490-491, back porch 492-524.
REQ-014 Counters SHALL advance only in cycles with pixel_en=1; with pixel_en=0 every output, pulses excepted, SHALL hold its value.
REQ-015 DrawX SHALL equal hc and DrawY SHALL equal vc, driven directly from the counter registers.
REQ-016 hs, vs and blank SHALL be registered outputs computed from the next counter values, so they align with DrawX/DrawY in the same cycle (zero skew).
REQ-017 hs SHALL be 0 iff 656<=DrawX<=751; vs SHALL be 0 iff 490<=DrawY<=491.
REQ-018 blank SHALL be 1 iff DrawX<640 and DrawY<480.
REQ-019 line_start SHALL be 1 for exactly one cycle in the cycle where hc transitions 799->0; frame_start SHALL additionally need vc transitioning 524->0.
REQ-020 Pulses SHALL be 0 in any cycle without a counter transition, including pixel_en=0 cycles.
REQ-021 All comparisons SHALL be unsigned 10-bit; counter values above 799/524 are unreachable and need no handling.

Reset
REQ-022 While reset_n=0: DrawX=0, DrawY=0, hs=1, vs=1, blank=1, frame_start=0, line_start=0, frame_cnt=0.
REQ-023 Reset SHALL take effect immediately, independent of vga_clk, including mid-line or mid-sync, with no partial-frame completion.
REQ-024 The first pixel_en=1 edge after release SHALL move to (1,0); no frame_start pulse SHALL occur for the reset-initiated frame.

Configuration
REQ-025 Macro VGA_FRAME_COUNT_EN defined: frame_cnt port exists and increments by 1 (mod 2^16, wrapping 65535->0) in the same cycle frame_start asserts.
REQ-026 Macro undefined: frame_cnt port and register are absent; all other behaviour is identical.

Verification
REQ-027 Reset, then pixel_en=1 for 420000 cycles -> frame_start period exactly 420000 cycles, line_start period 800, hs low 96 cycles per line, vs low 1600 cycles per frame.
REQ-028 Scan one full frame -> blank=1 for exactly 307200 cycles; blank falls at (640,y) and rises at (0,y) for y<480.
REQ-029 pixel_en toggling 1/0 each cycle -> all timings scale by 2 exactly; no pulse during pixel_en=0 cycles.
REQ-030 Assert reset_n=0 asynchronously at (700,491) with hs=0 and vs=0 -> outputs go to REQ-022 values before the next clock edge.
REQ-031 Release reset -> next edge gives DrawX=1, DrawY=0; the first frame_start arrives 419999 pixel steps later.
REQ-032 With VGA_FRAME_COUNT_EN and frame_cnt preloaded by forcing to 65535 -> the next frame_start returns frame_cnt to 0; without the macro the design elaborates with no frame_cnt port.
